ex_dmem_sequencer: RTL and testbench

- Sequences the two EX lanes of the dual-issue pipeline onto the single shared data-memory port.
- Each cycle it captures up to two memory operations, one per lane, and orders them by program age using ex2_older.
- It drives one req/gnt/rvalid transaction at a time, merging same-word load pairs, and holds both EX lanes stalled until their accesses complete.
- Sits between the EX coordination logic and the data-memory interface; its stall outputs feed the EX stall network alongside the store-hazard stalls.

---
 rtl/ex_dmem_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ex_dmem_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_dmem_sequencer.sv
// Dual-lane EX data-memory sequencer: orders up to two memops by program age onto
// one req/gnt/rvalid port, merging same-word load pairs, and stalls both lanes meanwhile.
module ex_dmem_sequencer #(
  parameter int MERGE_LOADS = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex1_valid,
  input  logic [3:0]  ex1_memop,
  input  logic [31:0] ex1_addr,
  input  logic [31:0] ex1_wdata,
  input  logic        ex2_valid,
  input  logic [3:0]  ex2_memop,
  input  logic [31:0] ex2_addr,
  input  logic [31:0] ex2_wdata,
  input  logic        ex2_older,
  output logic        ex1_stall,
  output logic        ex2_stall,
  output logic [31:0] ex1_rdata,
  output logic [31:0] ex2_rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);
  localparam logic [3:0] OP_SW = 4'd1, OP_SH = 4'd2, OP_SB = 4'd3, OP_LW = 4'd4,
                         OP_LH = 4'd5, OP_LB = 4'd6, OP_LHU = 4'd7, OP_LBU = 4'd8;

  typedef enum logic [2:0] {IDLE, REQ_A, RSP_A, REQ_B, RSP_B} state_e;

  state_e           state_q;
  logic [1:0][3:0]  op_q;
  logic [1:0][31:0] addr_q, wdata_q, rd_q;
  logic             a_lane_q, b_vld_q, merged_q;

  logic [1:0][3:0]  in_op;
  logic [1:0][31:0] in_addr, in_wdata, ext;
  logic [1:0]       act, ld, rsp;
  logic             a_lane_d, b_vld_d, merged_d, cur, stall;

  assign in_op    = {ex2_memop, ex1_memop};
  assign in_addr  = {ex2_addr, ex1_addr};
  assign in_wdata = {ex2_wdata, ex1_wdata};

  function automatic logic [31:0] extend(input logic [3:0] op, input logic [1:0] a,
                                         input logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? d[31:16] : d[15:0];
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    case (op)
      OP_LW:   extend = d;
      OP_LH:   extend = {{16{h[15]}}, h};
      OP_LHU:  extend = {16'h0, h};
      OP_LB:   extend = {{24{b[7]}}, b};
      OP_LBU:  extend = {24'h0, b};
      default: extend = 32'h0;
    endcase
  endfunction

  // Lane index 0 is EX lane 1, index 1 is EX lane 2; slot B always holds the other lane.
  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign act[i] = (i == 0 ? ex1_valid : ex2_valid) && in_op[i] != 4'd0 && in_op[i] <= OP_LBU;
    assign ld[i]  = in_op[i] >= OP_LW && in_op[i] <= OP_LBU;
    assign ext[i] = extend(op_q[i], addr_q[i][1:0], dm_rdata);
    assign rsp[i] = RST && dm_rvalid &&
                    ((state_q == RSP_A && (a_lane_q == 1'(i) || merged_q)) ||
                     (state_q == RSP_B && a_lane_q != 1'(i)));
  end

  always_comb begin
    merged_d = MERGE_LOADS != 0 && (&act) && ld[0] && ld[1] &&
               in_addr[0][31:2] == in_addr[1][31:2];
    b_vld_d  = (&act) && !merged_d;
    a_lane_d = (&act) ? ex2_older : act[1];
  end

  assign cur = (state_q == REQ_B || state_q == RSP_B) ? !a_lane_q : a_lane_q;

  always_comb begin
    dm_req   = RST && (state_q == REQ_A || state_q == REQ_B);
    dm_we    = 1'b0;
    dm_be    = 4'b0000;
    dm_addr  = {addr_q[cur][31:2], 2'b00};
    dm_wdata = wdata_q[cur];
    if (dm_req) begin
      case (op_q[cur])
        OP_SW: begin dm_we = 1'b1; dm_be = 4'b1111; end
        OP_SH: begin
          dm_we    = 1'b1;
          dm_be    = addr_q[cur][1] ? 4'b1100 : 4'b0011;
          dm_wdata = {2{wdata_q[cur][15:0]}};
        end
        OP_SB: begin
          dm_we    = 1'b1;
          dm_be    = 4'b0001 << addr_q[cur][1:0];
          dm_wdata = {4{wdata_q[cur][7:0]}};
        end
        default: dm_be = 4'b1111;
      endcase
    end
  end

  // Stall falls in the cycle the final rvalid lands so the pipe advances on that edge.
  always_comb begin
    stall = 1'b0;
    if (RST) begin
      case (state_q)
        IDLE:    stall = |act;
        RSP_A:   stall = !(dm_rvalid && !b_vld_q);
        RSP_B:   stall = !dm_rvalid;
        default: stall = 1'b1;
      endcase
    end
  end

  assign ex1_stall = stall;
  assign ex2_stall = stall;
  assign ex1_rdata = rsp[0] ? ext[0] : rd_q[0];
  assign ex2_rdata = rsp[1] ? ext[1] : rd_q[1];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      a_lane_q <= 1'b0;
      b_vld_q  <= 1'b0;
      merged_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|act) begin
          state_q  <= REQ_A;
          op_q     <= in_op;
          addr_q   <= in_addr;
          wdata_q  <= in_wdata;
          a_lane_q <= a_lane_d;
          b_vld_q  <= b_vld_d;
          merged_q <= merged_d;
          for (int i = 0; i < 2; i++) if (act[i]) rd_q[i] <= '0;
        end
        REQ_A:   if (dm_gnt) state_q <= RSP_A;
        RSP_A:   if (dm_rvalid) state_q <= b_vld_q ? REQ_B : IDLE;
        REQ_B:   if (dm_gnt) state_q <= RSP_B;
        RSP_B:   if (dm_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      for (int i = 0; i < 2; i++) if (rsp[i]) rd_q[i] <= ext[i];
    end
  end
endmodule

// File: tb/tb_ex_dmem_sequencer.sv
// Scoreboard bench: expected memory requests are queued at issue and popped as the DUT requests.
module tb_ex_dmem_sequencer;
  logic        CLK = 1'b0, RST = 1'b0, RST1 = 1'b0;
  logic        ex1_valid = 1'b0, ex2_valid = 1'b0, ex2_older = 1'b0;
  logic [3:0]  ex1_memop = '0, ex2_memop = '0;
  logic [31:0] ex1_addr = '0, ex1_wdata = '0, ex2_addr = '0, ex2_wdata = '0, dm_rdata = '0;
  logic        dm_gnt = 1'b0, dm_rvalid = 1'b0, gnt1 = 1'b0, rvalid1 = 1'b0;

  logic        ex1_stall, ex2_stall, dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] ex1_rdata, ex2_rdata, dm_addr, dm_wdata;
  logic        s1_1, s1_2, req1, we1;
  logic [3:0]  be1;
  logic [31:0] rd1_1, rd1_2, addr1, wdata1;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chkwd;
  } req_t;
  req_t exp_q[$];

  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  ex_dmem_sequencer #(.MERGE_LOADS(1)) u_dut (
    .CLK(CLK), .RST(RST),
    .ex1_valid(ex1_valid), .ex1_memop(ex1_memop), .ex1_addr(ex1_addr), .ex1_wdata(ex1_wdata),
    .ex2_valid(ex2_valid), .ex2_memop(ex2_memop), .ex2_addr(ex2_addr), .ex2_wdata(ex2_wdata),
    .ex2_older(ex2_older), .ex1_stall(ex1_stall), .ex2_stall(ex2_stall),
    .ex1_rdata(ex1_rdata), .ex2_rdata(ex2_rdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata));

  ex_dmem_sequencer #(.MERGE_LOADS(0)) u_nomerge (
    .CLK(CLK), .RST(RST1),
    .ex1_valid(ex1_valid), .ex1_memop(ex1_memop), .ex1_addr(ex1_addr), .ex1_wdata(ex1_wdata),
    .ex2_valid(ex2_valid), .ex2_memop(ex2_memop), .ex2_addr(ex2_addr), .ex2_wdata(ex2_wdata),
    .ex2_older(ex2_older), .ex1_stall(s1_1), .ex2_stall(s1_2),
    .ex1_rdata(rd1_1), .ex2_rdata(rd1_2), .dm_req(req1), .dm_we(we1),
    .dm_be(be1), .dm_addr(addr1), .dm_wdata(wdata1), .dm_gnt(gnt1),
    .dm_rvalid(rvalid1), .dm_rdata(dm_rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; gnt1 = 1'b0; rvalid1 = 1'b0;
  endtask

  task automatic drive(input bit lane2, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    if (lane2) begin ex2_valid = 1'b1; ex2_memop = op; ex2_addr = a; ex2_wdata = wd; end
    else       begin ex1_valid = 1'b1; ex1_memop = op; ex1_addr = a; ex1_wdata = wd; end
  endtask

  task automatic expect_req(input logic we, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] wd, input bit chkwd);
    req_t e;
    e.we = we; e.be = be; e.addr = a; e.wdata = wd; e.chkwd = chkwd;
    exp_q.push_back(e);
  endtask

  task automatic capture();
    @(negedge CLK);
    chk("cap_stall1", ex1_stall, 1);
    chk("cap_stall2", ex2_stall, 1);
    tick();
    ex1_valid = 1'b0; ex2_valid = 1'b0;
  endtask

  task automatic check_req(input req_t e);
    chk("req", dm_req, 1);
    chk("we", dm_we, e.we);
    chk("be", dm_be, e.be);
    chk("addr", dm_addr, e.addr);
    if (e.chkwd) chk("wdata", dm_wdata, e.wdata);
  endtask

  // Serves one access; returns at the negedge of the rvalid cycle.
  task automatic serve(input logic [31:0] rd, input int dly, input bit last);
    req_t e;
    int n = 0;
    @(negedge CLK);
    while (!dm_req && n < 20) begin tick(); @(negedge CLK); n++; end
    if (!dm_req || exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL req_wait: req=%b queued=%0d", dm_req, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    check_req(e);
    for (int d = 0; d < dly; d++) begin
      chk("hold_stall", ex1_stall, 1);
      tick(); @(negedge CLK);
      check_req(e);
    end
    dm_gnt = 1'b1;
    tick();
    dm_rvalid = 1'b1; dm_rdata = rd;
    @(negedge CLK);
    chk("rsp_stall1", ex1_stall, {31'b0, !last});
    chk("rsp_stall2", ex2_stall, {31'b0, !last});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    req_t e;
    repeat (2) tick();
    drive(0, 4'd4, 32'h100, 32'h0);
    @(negedge CLK);
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_stall1", ex1_stall, 0);
    chk("rst_stall2", ex2_stall, 0);
    chk("rst_rd1", ex1_rdata, 0);
    tick();
    ex1_valid = 1'b0;
    RST = 1'b1;
    tick();

    // single LW
    drive(0, 4'd4, 32'h100, 32'h0);
    expect_req(0, 4'hF, 32'h100, 32'h0, 0);
    capture();
    serve(32'hDEADBEEF, 0, 1);
    chk("t1_byp", ex1_rdata, 32'hDEADBEEF);
    tick(); @(negedge CLK);
    chk("t1_reg", ex1_rdata, 32'hDEADBEEF);
    chk("t1_idle_stall", ex1_stall, 0);
    tick();

    // lane 2 older store, then lane 1 LB
    ex2_older = 1'b1;
    drive(1, 4'd1, 32'h200, 32'h11223344);
    drive(0, 4'd6, 32'h203, 32'h0);
    expect_req(1, 4'hF, 32'h200, 32'h11223344, 1);
    expect_req(0, 4'hF, 32'h200, 32'h0, 0);
    capture();
    serve(32'h0, 0, 0);
    chk("t2_store_rd", ex2_rdata, 32'h0);
    tick();
    serve(32'h80000000, 0, 1);
    chk("t2_lb", ex1_rdata, 32'hFFFFFF80);
    tick();
    ex2_older = 1'b0;

    // merged same-word loads
    drive(0, 4'd4, 32'h300, 32'h0);
    drive(1, 4'd7, 32'h302, 32'h0);
    expect_req(0, 4'hF, 32'h300, 32'h0, 0);
    capture();
    serve(32'hABCD1234, 0, 1);
    chk("t3_lw", ex1_rdata, 32'hABCD1234);
    chk("t3_lhu", ex2_rdata, 32'h0000ABCD);
    tick(); @(negedge CLK);
    chk("t3_single", dm_req, 0);
    chk("t3_lhu_reg", ex2_rdata, 32'h0000ABCD);
    tick();

    // grant withheld 4 cycles
    drive(0, 4'd1, 32'h500, 32'hCAFEF00D);
    expect_req(1, 4'hF, 32'h500, 32'hCAFEF00D, 1);
    capture();
    serve(32'h0, 4, 1);
    tick();

    // SB / SH, lane 2 older
    ex2_older = 1'b1;
    drive(0, 4'd3, 32'h401, 32'h5A);
    drive(1, 4'd2, 32'h402, 32'hBEEF);
    expect_req(1, 4'b1100, 32'h400, 32'hBEEFBEEF, 1);
    expect_req(1, 4'b0010, 32'h400, 32'h5A5A5A5A, 1);
    capture();
    serve(32'h0, 0, 0);
    tick();
    serve(32'h0, 1, 1);
    tick();
    ex2_older = 1'b0;

    // reset while in RSP_B, then a stray rvalid
    drive(0, 4'd1, 32'h600, 32'h1);
    drive(1, 4'd4, 32'h604, 32'h0);
    expect_req(1, 4'hF, 32'h600, 32'h1, 1);
    expect_req(0, 4'hF, 32'h604, 32'h0, 0);
    capture();
    serve(32'h0, 0, 0);
    tick();
    @(negedge CLK);
    e = exp_q.pop_front();
    check_req(e);
    dm_gnt = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rstb_req", dm_req, 0);
    chk("rstb_stall", ex1_stall, 0);
    tick();
    RST = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'h12345678;
    @(negedge CLK);
    chk("stray_stall", ex2_stall, 0);
    chk("stray_rd2", ex2_rdata, 32'h0);
    chk("stray_req", dm_req, 0);
    tick(); @(negedge CLK);
    chk("post_rst_req", dm_req, 0);
    tick();

    // MERGE_LOADS=0 instance: same-word load pair must take two accesses
    RST = 1'b0;
    RST1 = 1'b1;
    tick();
    drive(0, 4'd4, 32'h300, 32'h0);
    drive(1, 4'd7, 32'h302, 32'h0);
    @(negedge CLK);
    chk("nm_cap_stall", s1_1, 1);
    tick();
    ex1_valid = 1'b0; ex2_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      @(negedge CLK);
      while (!req1 && n < 20) begin tick(); @(negedge CLK); n++; end
      chk("nm_req", req1, 1);
      chk("nm_addr", addr1, 32'h300);
      chk("nm_we", we1, 0);
      chk("nm_be", be1, 4'hF);
      gnt1 = 1'b1;
      tick();
      rvalid1 = 1'b1; dm_rdata = 32'hABCD1234;
      @(negedge CLK);
      chk("nm_stall", s1_2, {31'b0, k == 0});
      if (k == 0) chk("nm_rd1", rd1_1, 32'hABCD1234);
      else        chk("nm_rd2", rd1_2, 32'h0000ABCD);
      tick();
    end
    @(negedge CLK);
    chk("nm_done", req1, 0);
    chk("nm_rd1_reg", rd1_1, 32'hABCD1234);
    chk("nm_rd2_reg", rd1_2, 32'h0000ABCD);
    chk("nm_wd_unused", {31'b0, wdata1 === 32'hx}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
